// File: rtl/centroid_multi.sv
// Multi-channel centroid engine: per-channel x/y sums and pixel counts over a frame,
// then a shared restoring divider reports floor(sum/mass) for each channel in turn.
module centroid_multi #(
  parameter int NUM_CH   = 4,
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int CNT_W    = 20,
  parameter int MIN_MASS = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [NUM_CH-1:0] valid_in,
  input  logic              tabulate_in,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [CNT_W-1:0]  mass_out,
  output logic [CH_W-1:0]   ch_out,
  output logic              found_out,
  output logic              valid_out,
  output logic              frame_done_out,
  output logic              busy_out,
  output logic              overrun_out
);

  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int IT_W = $clog2(X_W + 1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W:0]   MIN_M   = (CNT_W + 1)'(MIN_MASS);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, EMIT} state_t;

  state_t            state;
  logic [SX_W-1:0]   sum_x [NUM_CH];
  logic [SY_W-1:0]   sum_y [NUM_CH];
  logic [CNT_W-1:0]  mass  [NUM_CH];
  logic [SX_W-1:0]   sh_x  [NUM_CH];
  logic [SY_W-1:0]   sh_y  [NUM_CH];
  logic [CNT_W-1:0]  sh_m  [NUM_CH];

  logic [CH_W-1:0]   ch_idx;
  logic [IT_W-1:0]   it;
  logic [CNT_W-1:0]  div_m;
  logic [CNT_W-1:0]  rem_x, rem_y, nrem_x, nrem_y;
  logic [X_W-1:0]    low_x, low_y, nlow_x, nlow_y;
  logic [SX_W-1:0]   ysel;

  // One restoring step. The low register shifts dividend bits out of its MSB and
  // quotient bits into its LSB, so after X_W steps it holds the quotient.
  function automatic logic [CNT_W+X_W-1:0] div_step(input logic [CNT_W-1:0] rem,
                                                    input logic [X_W-1:0]   low,
                                                    input logic [CNT_W-1:0] d);
    logic [CNT_W:0] trial;
    trial = {rem, low[X_W-1]};
    if (trial >= {1'b0, d})
      return {CNT_W'(trial - {1'b0, d}), low[X_W-2:0], 1'b1};
    else
      return {trial[CNT_W-1:0], low[X_W-2:0], 1'b0};
  endfunction

  assign {nrem_x, nlow_x} = div_step(rem_x, low_x, div_m);
  assign {nrem_y, nlow_y} = div_step(rem_y, low_y, div_m);
  assign ysel = SX_W'(sh_y[ch_idx]);

  // Accumulate stage; a tabulate restarts from the current pixel and, when idle,
  // snapshots the pre-update totals.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sum_x[c] <= '0;
        sum_y[c] <= '0;
        mass[c]  <= '0;
        sh_x[c]  <= '0;
        sh_y[c]  <= '0;
        sh_m[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tabulate_in) begin
          sum_x[c] <= valid_in[c] ? SX_W'(x_in) : '0;
          sum_y[c] <= valid_in[c] ? SY_W'(y_in) : '0;
          mass[c]  <= valid_in[c] ? CNT_W'(1) : '0;
        end else if (valid_in[c] && !(&mass[c])) begin
          sum_x[c] <= sum_x[c] + SX_W'(x_in);
          sum_y[c] <= sum_y[c] + SY_W'(y_in);
          mass[c]  <= mass[c] + CNT_W'(1);
        end
        if (tabulate_in && !busy_out) begin
          sh_x[c] <= sum_x[c];
          sh_y[c] <= sum_y[c];
          sh_m[c] <= mass[c];
        end
      end
    end
  end

  // Sequencer and divider stage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      ch_idx         <= '0;
      it             <= '0;
      div_m          <= '0;
      rem_x          <= '0;
      rem_y          <= '0;
      low_x          <= '0;
      low_y          <= '0;
      x_out          <= '0;
      y_out          <= '0;
      mass_out       <= '0;
      ch_out         <= '0;
      found_out      <= 1'b0;
      valid_out      <= 1'b0;
      frame_done_out <= 1'b0;
      busy_out       <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      valid_out      <= 1'b0;
      frame_done_out <= 1'b0;
      overrun_out    <= tabulate_in && busy_out;
      case (state)
        IDLE: begin
          if (tabulate_in) begin
            state    <= LOAD;
            ch_idx   <= '0;
            busy_out <= 1'b1;
          end
        end
        LOAD: begin
          div_m <= sh_m[ch_idx];
          rem_x <= sh_x[ch_idx][SX_W-1:X_W];
          low_x <= sh_x[ch_idx][X_W-1:0];
          rem_y <= ysel[SX_W-1:X_W];
          low_y <= ysel[X_W-1:0];
          it    <= '0;
          state <= DIV;
        end
        DIV: begin
          rem_x <= nrem_x;
          low_x <= nlow_x;
          rem_y <= nrem_y;
          low_y <= nlow_y;
          it    <= it + IT_W'(1);
          if (it == IT_W'(X_W - 1)) begin
            state          <= EMIT;
            valid_out      <= 1'b1;
            frame_done_out <= (ch_idx == LAST_CH);
            ch_out         <= ch_idx;
            mass_out       <= div_m;
            if (div_m == '0) begin
              x_out     <= '0;
              y_out     <= '0;
              found_out <= 1'b0;
            end else begin
              x_out     <= nlow_x;
              y_out     <= nlow_y[Y_W-1:0];
              found_out <= ({1'b0, div_m} >= MIN_M);
            end
          end
        end
        EMIT: begin
          if (ch_idx == LAST_CH) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else begin
            ch_idx <= ch_idx + CH_W'(1);
            state  <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/centroid_multi.md
# centroid_multi

Multi-channel centroid engine for the camera pipeline. It accumulates x/y coordinate sums and pixel counts for up to NUM_CH independent pixel masks (e.g. one per colour threshold) in a single pass over a frame. On a tabulate pulse it snapshots all channels and runs a shared restoring divider over each channel in turn, emitting one centroid per channel. It sits after the threshold/mask stage and feeds the overlay/tracking logic.

## Interface
- NUM_CH, 4: number of mask channels (1..16); CH_W = max(1, clog2(NUM_CH))
- X_W, 11: x coordinate width
- Y_W, 10: y coordinate width; must be ≤ X_W
- CNT_W, 20: per-channel pixel count width; sums are X_W+CNT_W and Y_W+CNT_W bits
- MIN_MASS, 16: minimum pixel count for a centroid to be reported as found
- clk_in  in  1  pixel clock
- rst_n_in  in  1  reset, asynchronous, active-low
- x_in  in  X_W  current pixel column
- y_in  in  Y_W  current pixel row
- valid_in  in  NUM_CH  per-channel mask hit for the current pixel
- tabulate_in  in  1  one-cycle end-of-frame pulse
- x_out  out  X_W  floor(sum_x / mass) for ch_out
- y_out  out  Y_W  floor(sum_y / mass) for ch_out
- mass_out  out  CNT_W  pixel count of ch_out
- ch_out  out  CH_W  channel index of current result
- found_out  out  1  mass_out ≥ MIN_MASS and mass_out ≠ 0
- valid_out  out  1  one-cycle result strobe
- frame_done_out  out  1  pulses with the last channel's valid_out
- busy_out  out  1  divider sequence in progress
- overrun_out  out  1  one-cycle pulse: tabulate_in rejected

## Operation
- Accumulate: each cycle, for every channel c with valid_in[c]=1: sum_x[c] += x_in, sum_y[c] += y_in, mass[c] += 1.
- Saturation: when mass[c] is all ones, channel c stops updating entirely (sums and mass are held). No other overflow handling is needed; sum widths make overflow impossible.
- Tabulate cycle:
  - Accumulators restart from this cycle's pixel: value valid_in[c] ? x_in : 0, and likewise for y and mass. That pixel counts toward the next frame.
  - If busy_out=0, the pre-update accumulator values are copied into shadow registers and the sequence starts.
  - If busy_out=1, nothing is snapshotted, the running sequence is unaffected, and overrun_out pulses.
- FSM states: IDLE, LOAD, DIV, EMIT.
  - IDLE → LOAD on an accepted tabulate, with channel index = 0.
  - LOAD (1 cycle): load channel index's shadow sums and mass into two parallel dividers.
  - DIV (exactly X_W cycles): one restoring quotient bit per cycle, MSB first. The y divider also runs X_W iterations; its quotient is truncated to Y_W bits.
  - EMIT (1 cycle): drive outputs and assert valid_out. Then go to LOAD with index+1, or to IDLE after channel NUM_CH-1.
- mass=0: run the same state sequence. Force x_out=y_out=0 and found_out=0 (no divide-by-zero hazard).
- Results: x_out, y_out, mass_out, ch_out and found_out are registered and hold their value between strobes.

## Timing
- L = X_W+2 cycles per channel (11-bit default: L=13).
- Accepted tabulate at cycle T:
  - busy_out is high from T+1 through T+NUM_CH·L inclusive.
  - valid_out for channel k is at cycle T+(k+1)·L.
  - frame_done_out is at T+NUM_CH·L.
- A tabulate at T+NUM_CH·L is rejected (overrun). A tabulate at T+NUM_CH·L+1 is accepted.
- Reset values: every output 0; all accumulators, shadows and dividers 0; FSM in IDLE.
- Reset asserted mid-sequence aborts immediately: no further valid_out, and no stale result after release.
- Throughput: one frame per NUM_CH·L+1 cycles minimum, which is far below the frame period.

## Test plan
- Single channel (MIN_MASS=1): ch0 hits at (10,20), (20,40), (30,60), then tabulate at T → at T+13: ch_out=0, x_out=20, y_out=40, mass_out=3, found_out=1. Channels 1–3 report mass 0, found 0, at T+26/39/52; frame_done_out at T+52.
- Floor and boundary: ch1 hits at (1,1), (2,2) → x_out=1, y_out=1. Hits at (2047,1023) ×2 → x_out=2047, y_out=1023.
- Threshold (MIN_MASS=16): ch2 with 15 hits → found_out=0 with correct x/y/mass. 16 hits → found_out=1.
- Tabulate-cycle pixel: valid_in=4'b1111 at (5,5) coincident with tabulate → that pixel is absent from the current results. The next frame's tabulate alone reports mass_out=1, x=5, y=5 on all channels.
- Overrun: second tabulate at T+52 → overrun_out pulses, and the in-flight results are unchanged. Second tabulate at T+53 → accepted, busy_out=1 at T+54.
- Async reset: drop rst_n_in mid-DIV of ch1 (no clock edge needed) → all outputs go to 0 immediately. After release, no valid_out appears until a new tabulate.
